// File: rtl/reg_cut_pkg.sv
// Shared types for the register-interface cut: FSM state encoding and the
// default request/response structs used by the cut and its environment.
package reg_cut_pkg;

    localparam int unsigned REG_AW = 32;
    localparam int unsigned REG_DW = 32;
    localparam int unsigned REG_SW = REG_DW / 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RESPOND = 2'd2
    } reg_cut_state_e;

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic              write;
        logic [REG_DW-1:0] wdata;
        logic [REG_SW-1:0] wstrb;
        logic              valid;
    } reg_req_t;

    typedef struct packed {
        logic [REG_DW-1:0] rdata;
        logic              error;
        logic              ready;
    } reg_rsp_t;

endpackage

// File: rtl/reg_timeout_cnt.sv
// Saturating wait counter for the ISSUE phase; expired flags the last
// permitted cycle. TimeoutCycles = 0 turns the timeout off entirely.
module reg_timeout_cnt #(
    parameter int unsigned TimeoutCycles = 256
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [CW-1:0] LAST = CW'((TimeoutCycles == 0) ? 0 : TimeoutCycles - 1);

    logic [CW-1:0] r_cnt;

    assign expired = (TimeoutCycles != 0) && en && (r_cnt == LAST);

    // Holds at LAST instead of wrapping, so a stalled ISSUE never re-arms.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr) begin
            r_cnt <= '0;
        end else if (en && !expired) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/reg_cut_timeout.sv
// Register-interface pipeline cut: every output comes from a flop or the FSM
// state, and a stalled downstream is answered with an error after a timeout.
module reg_cut_timeout
    import reg_cut_pkg::*;
#(
    parameter type             req_t         = logic,
    parameter type             rsp_t         = logic,
    parameter int unsigned     DW            = 32,
    parameter int unsigned     TimeoutCycles = 256,
    parameter logic [DW-1:0]   TimeoutRdata  = 32'hDEAD_BEEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  req_t in_req_i,
    output rsp_t in_rsp_o,
    output req_t out_req_o,
    input  rsp_t out_rsp_i,
    output logic timeout_o,
    output logic busy_o
);

    reg_req_t       w_in_req;
    reg_rsp_t       w_out_rsp;
    reg_req_t       w_out_req;
    reg_rsp_t       w_in_rsp;

    reg_cut_state_e r_state;
    reg_cut_state_e w_state_next;
    logic           w_capture;
    logic           w_accept;
    logic           w_timeout;
    logic           w_expired;

    logic [REG_AW-1:0] r_addr;
    logic              r_write;
    logic [REG_DW-1:0] r_wdata;
    logic [REG_SW-1:0] r_wstrb;
    logic [DW-1:0]     r_rdata;
    logic              r_error;
    logic              r_timeout;

    assign w_in_req  = reg_req_t'(in_req_i);
    assign w_out_rsp = reg_rsp_t'(out_rsp_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_accept     = 1'b0;
        w_timeout    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_in_req.valid) begin
                    w_capture    = 1'b1;
                    w_state_next = ISSUE;
                end
            end
            ISSUE: begin
                // A ready in the expiry cycle wins over the timeout.
                if (w_out_rsp.ready) begin
                    w_accept     = 1'b1;
                    w_state_next = RESPOND;
                end else if (w_expired) begin
                    w_timeout    = 1'b1;
                    w_state_next = RESPOND;
                end
            end
            RESPOND: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    reg_timeout_cnt #(
        .TimeoutCycles(TimeoutCycles)
    ) u_timeout_cnt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr    (w_capture),
        .en     (r_state == ISSUE),
        .expired(w_expired)
    );

    // NOTE: sequential state uses non-blocking assignments only; captured fields are reset so out_req_o reads zero after reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_addr    <= '0;
            r_write   <= 1'b0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_rdata   <= '0;
            r_error   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_timeout;
            if (w_capture) begin
                r_addr  <= w_in_req.addr;
                r_write <= w_in_req.write;
                r_wdata <= w_in_req.wdata;
                r_wstrb <= w_in_req.wstrb;
            end
            if (w_accept) begin
                r_rdata <= DW'(w_out_rsp.rdata);
                r_error <= w_out_rsp.error;
            end else if (w_timeout) begin
                r_rdata <= TimeoutRdata;
                r_error <= 1'b1;
            end
        end
    end

    always_comb begin
        w_out_req.addr  = r_addr;
        w_out_req.write = r_write;
        w_out_req.wdata = r_wdata;
        w_out_req.wstrb = r_wstrb;
        w_out_req.valid = (r_state == ISSUE);

        w_in_rsp = '0;
        if (r_state == RESPOND) begin
            w_in_rsp.rdata = REG_DW'(r_rdata);
            w_in_rsp.error = r_error;
            w_in_rsp.ready = 1'b1;
        end
    end

    assign out_req_o = req_t'(w_out_req);
    assign in_rsp_o  = rsp_t'(w_in_rsp);
    assign timeout_o = r_timeout;
    assign busy_o    = (r_state != IDLE);

endmodule

// File: tb/tb_reg_cut_timeout.sv
// Bench for reg_cut_timeout: table of transactions with a scripted downstream
// responder and a response scoreboard, plus reset and back-to-back sequences.
module tb_reg_cut_timeout;
    import reg_cut_pkg::*;

    logic     clk = 1'b0;
    logic     rst;
    reg_req_t in_req;
    reg_rsp_t in_rsp;
    reg_req_t out_req;
    reg_rsp_t out_rsp;
    logic     timeout;
    logic     busy;

    int errors = 0;
    int checks = 0;
    int issue_starts = 0;
    logic prev_valid = 1'b0;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          delay;       // ISSUE cycle in which ready is given, 0 = never
        logic [31:0] rsp_rdata;
        logic        rsp_error;
        logic [31:0] exp_rdata;
        logic        exp_error;
        int          exp_timeout;
        int          exp_lat;     // cycle of upstream ready, valid cycle = 1
    } vec_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
    } exp_t;

    localparam int NVEC = 6;
    vec_t vecs [NVEC];
    exp_t sb_q [$];

    always #5 clk = ~clk;

    reg_cut_timeout #(
        .req_t        (reg_req_t),
        .rsp_t        (reg_rsp_t),
        .DW           (32),
        .TimeoutCycles(8),
        .TimeoutRdata (32'hDEAD_BEEF)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .in_req_i (in_req),
        .in_rsp_o (in_rsp),
        .out_req_o(out_req),
        .out_rsp_i(out_rsp),
        .timeout_o(timeout),
        .busy_o   (busy)
    );

    always @(negedge clk) begin
        if (out_req.valid && !prev_valid) issue_starts++;
        prev_valid = out_req.valid;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Entered and left at a falling edge; leaves the request driven (valid=1).
    task automatic run_txn(input vec_t v, input int idx);
        int   cyc    = 1;
        int   issues = 0;
        int   to_cnt = 0;
        bit   done   = 0;
        bit   clean  = 1;
        exp_t e;
        in_req = '{addr: v.addr, write: v.write, wdata: v.wdata, wstrb: v.wstrb, valid: 1'b1};
        sb_q.push_back('{rdata: v.exp_rdata, error: v.exp_error});
        while (!done && cyc <= 40) begin
            out_rsp = '0;
            if (timeout) to_cnt++;
            if (out_req.valid) begin
                issues++;
                if (issues == 1) begin
                    check($sformatf("v%0d_addr", idx), 64'(out_req.addr), 64'(v.addr));
                    check($sformatf("v%0d_write", idx), 64'(out_req.write), 64'(v.write));
                    check($sformatf("v%0d_wdata", idx), 64'(out_req.wdata), 64'(v.wdata));
                    check($sformatf("v%0d_wstrb", idx), 64'(out_req.wstrb), 64'(v.wstrb));
                end
                if (issues == v.delay)
                    out_rsp = '{rdata: v.rsp_rdata, error: v.rsp_error, ready: 1'b1};
            end
            if (in_rsp.ready) begin
                done = 1;
                check($sformatf("v%0d_latency", idx), 64'(cyc), 64'(v.exp_lat));
                check($sformatf("v%0d_valid_in_respond", idx), 64'(out_req.valid), 64'd0);
                if (sb_q.size() == 0) begin
                    check($sformatf("v%0d_sb_underflow", idx), 64'd1, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    check($sformatf("v%0d_rdata", idx), 64'(in_rsp.rdata), 64'(e.rdata));
                    check($sformatf("v%0d_error", idx), 64'(in_rsp.error), 64'(e.error));
                end
            end else if (in_rsp != '0) begin
                clean = 0;
            end
            @(negedge clk);
            cyc++;
        end
        out_rsp = '0;
        if (!done) check($sformatf("v%0d_response_wait_bound", idx), 64'd0, 64'd1);
        check($sformatf("v%0d_timeout_pulses", idx), 64'(to_cnt), 64'(v.exp_timeout));
        check($sformatf("v%0d_idle_busy", idx), 64'(busy), 64'd0);
        check($sformatf("v%0d_idle_valid", idx), 64'(out_req.valid), 64'd0);
        check($sformatf("v%0d_idle_timeout", idx), 64'(timeout), 64'd0);
        check($sformatf("v%0d_rsp_zero_outside_respond", idx), 64'(clean), 64'd1);
    endtask

    initial begin
        bit stray;
        //          wr    addr         wdata         strb  dly rsp_rdata     rerr  exp_rdata     eerr  to lat
        vecs[0] = '{1'b0, 32'h0000_0010, 32'h0,        4'h0, 2, 32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0, 0, 4};
        vecs[1] = '{1'b1, 32'h0000_0020, 32'hA5A5_A5A5, 4'hF, 1, 32'h0,        1'b0, 32'h0,        1'b0, 0, 3};
        vecs[2] = '{1'b0, 32'h0000_0030, 32'h0,        4'h0, 0, 32'h0,        1'b0, 32'hDEAD_BEEF, 1'b1, 1, 10};
        vecs[3] = '{1'b0, 32'h0000_0034, 32'h0,        4'h0, 8, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 1'b0, 0, 10};
        vecs[4] = '{1'b1, 32'h0000_0040, 32'h0000_00FF, 4'h0, 3, 32'h0000_0055, 1'b1, 32'h0000_0055, 1'b1, 0, 5};
        vecs[5] = '{1'b0, 32'h0000_0044, 32'h0,        4'h0, 7, 32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D, 1'b0, 0, 9};

        rst     = 1'b1;
        in_req  = '0;
        out_rsp = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_in_rsp_zero", 64'(in_rsp == '0), 64'd1);
        check("reset_out_req_zero", 64'(out_req == '0), 64'd1);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_timeout", 64'(timeout), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Valid stays high across all vectors: back-to-back traffic.
        for (int i = 0; i < NVEC; i++) run_txn(vecs[i], i);
        in_req.valid = 1'b0;
        repeat (2) @(negedge clk);
        check("b2b_issue_count", 64'(issue_starts), 64'(NVEC));
        check("sb_empty", 64'(sb_q.size()), 64'd0);

        // Reset while the downstream request is outstanding.
        in_req = '{addr: 32'h50, write: 1'b1, wdata: 32'h1111_2222, wstrb: 4'h3, valid: 1'b1};
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_issue_valid_before", 64'(out_req.valid), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_issue_valid", 64'(out_req.valid), 64'd0);
        check("rst_mid_issue_busy", 64'(busy), 64'd0);
        check("rst_mid_issue_ready", 64'(in_rsp.ready), 64'd0);
        check("rst_mid_issue_addr_cleared", 64'(out_req.addr), 64'd0);
        in_req.valid = 1'b0;
        @(negedge clk);
        rst   = 1'b0;
        stray = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (in_rsp.ready || out_req.valid || busy) stray = 1'b1;
        end
        check("rst_mid_issue_no_stray", 64'(stray), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
